// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: forwards ALU results and issues loads/stores over valid/ready.
// Optional feature: define MEM_MISALIGN_EXC_EN to trap misaligned accesses instead of aligning them.

module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [6:0]        ex_opcode,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic [31:0]       ex_instruction,
    output logic              mem_stall,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_data,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_value,
    output logic [6:0]        wb_opcode,
    output logic [RD_W-1:0]   wb_rd,
    output logic [31:0]       wb_instruction,
    output logic              wb_exc
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(XLEN);

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state;
    logic [1:0]        cap_size;
    logic              cap_uns;
    logic [OFF_W-1:0]  cap_off;
    logic [6:0]        cap_opcode;
    logic [RD_W-1:0]   cap_rd;
    logic [31:0]       cap_instr;

    logic              is_alu, is_mem, take_exc;
    logic [1:0]        ex_size;
    logic [OFF_W-1:0]  off_raw, low_mask, ex_off;
    logic [NB-1:0]     ex_strb;
    logic [XLEN-1:0]   ex_wdata;
    logic [ADDR_W-1:0] ex_addr;
    logic [XLEN-1:0]   rsp_lane, load_value;
    logic [IDX_W-1:0]  ld_msb;
    int                ld_bits;

    assign mem_stall      = (state != IDLE);
    assign dmem_req_valid = (state == REQ);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_alu  = (ex_opcode == OP_ALU_R) || (ex_opcode == OP_ALU_I);
        is_mem  = (ex_opcode == OP_LOAD) || (ex_opcode == OP_STORE);
        ex_size = ex_funct3[1:0];
        if (XLEN == 32 && ex_size == 2'd3) ex_size = 2'd2;
        case (ex_size)
            2'd0:    low_mask = '0;
            2'd1:    low_mask = OFF_W'(1);
            2'd2:    low_mask = OFF_W'(3);
            default: low_mask = OFF_W'(7);
        endcase
        off_raw = ex_alu_result[OFF_W-1:0];
        ex_off  = off_raw & ~low_mask;
`ifdef MEM_MISALIGN_EXC_EN
        take_exc = is_mem && ((off_raw & low_mask) != '0);
`else
        take_exc = 1'b0;
`endif
        ex_strb = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(ex_off) && i < int'(ex_off) + (1 << ex_size)) ex_strb[i] = 1'b1;
        end
        // Replicate the store operand so every lane carries it; strobes pick the live bytes.
        case (ex_size)
            2'd0:    ex_wdata = {(XLEN/8){ex_store_data[7:0]}};
            2'd1:    ex_wdata = {(XLEN/16){ex_store_data[15:0]}};
            2'd2:    ex_wdata = {(XLEN/32){ex_store_data[31:0]}};
            default: ex_wdata = ex_store_data;
        endcase
        ex_addr = ADDR_W'(ex_alu_result) & ~ADDR_W'(NB - 1);
    end

    always_comb begin
        rsp_lane = dmem_rsp_data >> {cap_off, 3'b000};
        ld_bits  = 8 << cap_size;
        ld_msb   = IDX_W'(ld_bits - 1);
        for (int i = 0; i < XLEN; i++) begin
            load_value[i] = (i < ld_bits) ? rsp_lane[i] : (!cap_uns && rsp_lane[ld_msb]);
        end
    end

`ifndef MEM_MISALIGN_EXC_EN
    assign wb_exc = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
            wb_valid       <= 1'b0;
            wb_value       <= '0;
            wb_opcode      <= '0;
            wb_rd          <= '0;
            wb_instruction <= '0;
            cap_size       <= '0;
            cap_uns        <= 1'b0;
            cap_off        <= '0;
            cap_opcode     <= '0;
            cap_rd         <= '0;
            cap_instr      <= '0;
`ifdef MEM_MISALIGN_EXC_EN
            wb_exc         <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (ex_valid) begin
                    if (is_alu || take_exc) begin
                        wb_valid       <= 1'b1;
                        wb_value       <= ex_alu_result;
                        wb_opcode      <= ex_opcode;
                        wb_rd          <= ex_rd;
                        wb_instruction <= ex_instruction;
`ifdef MEM_MISALIGN_EXC_EN
                        wb_exc         <= take_exc;
`endif
                    end else if (is_mem) begin
                        state      <= REQ;
                        dmem_we    <= (ex_opcode == OP_STORE);
                        dmem_addr  <= ex_addr;
                        dmem_wdata <= ex_wdata;
                        dmem_wstrb <= ex_strb;
                        cap_size   <= ex_size;
                        cap_uns    <= ex_funct3[2];
                        cap_off    <= ex_off;
                        cap_opcode <= ex_opcode;
                        cap_rd     <= ex_rd;
                        cap_instr  <= ex_instruction;
                    end
                end
                REQ: if (dmem_req_ready) begin
                    if (dmem_we) begin
                        state          <= IDLE;
                        wb_valid       <= 1'b1;
                        wb_value       <= '0;
                        wb_opcode      <= cap_opcode;
                        wb_rd          <= cap_rd;
                        wb_instruction <= cap_instr;
`ifdef MEM_MISALIGN_EXC_EN
                        wb_exc         <= 1'b0;
`endif
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (dmem_rsp_valid) begin
                    state          <= IDLE;
                    wb_valid       <= 1'b1;
                    wb_value       <= load_value;
                    wb_opcode      <= cap_opcode;
                    wb_rd          <= cap_rd;
                    wb_instruction <= cap_instr;
`ifdef MEM_MISALIGN_EXC_EN
                    wb_exc         <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32) against an arithmetic reference model.
// Honours MEM_MISALIGN_EXC_EN when the design is built with it.

module tb_mem_access_unit;

    localparam int XLEN = 32;
    localparam int ADDR_W = 32;
    localparam int RD_W = 5;
    localparam logic [6:0] OP_R  = 7'h33;
    localparam logic [6:0] OP_I  = 7'h13;
    localparam logic [6:0] OP_LD = 7'h03;
    localparam logic [6:0] OP_ST = 7'h23;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ex_valid = 1'b0;
    logic [6:0]        ex_opcode = '0;
    logic [2:0]        ex_funct3 = '0;
    logic [XLEN-1:0]   ex_alu_result = '0;
    logic [XLEN-1:0]   ex_store_data = '0;
    logic [RD_W-1:0]   ex_rd = '0;
    logic [31:0]       ex_instruction = '0;
    logic              mem_stall, dmem_req_valid, dmem_we;
    logic              dmem_req_ready = 1'b0;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_wstrb;
    logic              dmem_rsp_valid = 1'b0;
    logic [XLEN-1:0]   dmem_rsp_data = '0;
    logic              wb_valid, wb_exc;
    logic [XLEN-1:0]   wb_value;
    logic [6:0]        wb_opcode;
    logic [RD_W-1:0]   wb_rd;
    logic [31:0]       wb_instruction;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_hs = 0;

    mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_instruction(ex_instruction), .mem_stall(mem_stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data), .wb_valid(wb_valid),
        .wb_value(wb_value), .wb_opcode(wb_opcode), .wb_rd(wb_rd),
        .wb_instruction(wb_instruction), .wb_exc(wb_exc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        if (reset && dmem_req_valid && dmem_req_ready) n_hs++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: plain arithmetic on sizes and byte offsets.
    function automatic int m_size(input logic [2:0] f3);
        int s;
        s = int'(f3[1:0]);
        if (s == 3 && XLEN == 32) s = 2;
        return s;
    endfunction

    function automatic int m_off(input logic [31:0] addr, input logic [2:0] f3);
        int nb, o;
        nb = 1 << m_size(f3);
        o  = int'(addr % 4);
        return o - (o % nb);
    endfunction

    function automatic logic [3:0] m_strb(input int nb, input int off);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] data, input int nb);
        longint pat, w;
        pat = longint'(data) & ((64'sd1 <<< (8 * nb)) - 1);
        w = 0;
        for (int k = 0; k < 4 / nb; k++) w = w | (pat << (8 * nb * k));
        return 32'(w);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rsp, input int off, input logic [2:0] f3);
        int nb;
        longint mask, v;
        nb   = 1 << m_size(f3);
        mask = (64'sd1 <<< (8 * nb)) - 1;
        v    = (longint'(rsp) >> (8 * off)) & mask;
        if (!f3[2] && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
        return 32'(v);
    endfunction

    task automatic do_mem_op(input string name, input bit st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int rdy_dly, input int rsp_dly, input logic [31:0] rsp);
        int nb, off;
        logic [4:0] rd;
        logic [31:0] instr, exp_v;
        logic [3:0] exp_strb;
        logic [31:0] exp_wd;
        nb = 1 << m_size(f3);
        off = m_off(addr, f3);
        rd = 5'($urandom);
        instr = $urandom;
        ex_valid = 1'b1; ex_opcode = st ? OP_ST : OP_LD; ex_funct3 = f3;
        ex_alu_result = addr; ex_store_data = data; ex_rd = rd; ex_instruction = instr;
        step();
        ex_valid = 1'b0; ex_opcode = 7'h00; ex_alu_result = $urandom; ex_store_data = $urandom;
`ifdef MEM_MISALIGN_EXC_EN
        if (addr % nb != 0) begin
            n_checks++;
            if ({dmem_req_valid, mem_stall, wb_valid, wb_exc, wb_rd} !== {4'b0011, rd}) begin
                n_fail++;
                $display("FAIL %s exc_flags: got %b want %b", name,
                         {dmem_req_valid, mem_stall, wb_valid, wb_exc, wb_rd}, {4'b0011, rd});
            end
            n_checks++;
            if (wb_value !== addr) begin
                n_fail++;
                $display("FAIL %s exc_value: got %h want %h", name, wb_value, addr);
            end
            step();
            return;
        end
`endif
        exp_strb = m_strb(nb, off);
        exp_wd = m_wdata(data, nb);
        for (int k = 0; k <= rdy_dly; k++) begin
            n_checks++;
            if ({dmem_req_valid, mem_stall, dmem_we, wb_valid} !== {2'b11, st, 1'b0}) begin
                n_fail++;
                $display("FAIL %s req_flags[%0d]: got %b want %b", name, k,
                         {dmem_req_valid, mem_stall, dmem_we, wb_valid}, {2'b11, st, 1'b0});
            end
            n_checks++;
            if (dmem_addr !== (addr & ~32'h3)) begin
                n_fail++;
                $display("FAIL %s addr[%0d]: got %h want %h", name, k, dmem_addr, addr & ~32'h3);
            end
            if (st) begin
                n_checks++;
                if ({dmem_wstrb, dmem_wdata} !== {exp_strb, exp_wd}) begin
                    n_fail++;
                    $display("FAIL %s strb_wdata[%0d]: got %b/%h want %b/%h", name, k,
                             dmem_wstrb, dmem_wdata, exp_strb, exp_wd);
                end
            end
            dmem_req_ready = (k == rdy_dly);
            dmem_rsp_valid = (k != rdy_dly);
            dmem_rsp_data = $urandom;
            step();
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        exp_v = 32'h0;
        if (!st) begin
            for (int k = 0; k <= rsp_dly; k++) begin
                n_checks++;
                if ({mem_stall, dmem_req_valid, wb_valid} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL %s wait_flags[%0d]: got %b want 100", name, k,
                             {mem_stall, dmem_req_valid, wb_valid});
                end
                dmem_rsp_valid = (k == rsp_dly);
                dmem_rsp_data = (k == rsp_dly) ? rsp : $urandom;
                step();
            end
            dmem_rsp_valid = 1'b0;
            exp_v = m_load(rsp, off, f3);
        end
        n_checks++;
        if ({wb_valid, mem_stall, wb_exc, wb_opcode, wb_rd} !== {3'b100, st ? OP_ST : OP_LD, rd}) begin
            n_fail++;
            $display("FAIL %s wb_flags: got %b want %b", name, {wb_valid, mem_stall, wb_exc, wb_opcode, wb_rd},
                     {3'b100, st ? OP_ST : OP_LD, rd});
        end
        n_checks++;
        if ({wb_value, wb_instruction} !== {exp_v, instr}) begin
            n_fail++;
            $display("FAIL %s wb_value: got %h/%h want %h/%h", name, wb_value, wb_instruction, exp_v, instr);
        end
        step();
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wb_pulse: got %b want 0", name, wb_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ex_valid = 1'b1; ex_opcode = OP_R; ex_alu_result = $urandom;
        step();
        step();
        n_checks++;
        if ({mem_stall, dmem_req_valid, dmem_we, dmem_wstrb, wb_valid, wb_exc} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0", {mem_stall, dmem_req_valid, dmem_we, dmem_wstrb, wb_valid, wb_exc});
        end
        n_checks++;
        if ({dmem_addr, dmem_wdata, wb_value, wb_opcode, wb_rd, wb_instruction} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h/%h/%h want all 0", dmem_addr, dmem_wdata,
                     wb_value, wb_opcode, wb_rd, wb_instruction);
        end
        ex_valid = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_alu();
        logic [31:0] val, instr;
        logic [6:0] op;
        logic [4:0] rd;
        for (int i = 0; i < 6; i++) begin
            op = (i % 2 == 1) ? OP_I : OP_R;
            val = (i == 0) ? 32'h0000_1234 : $urandom;
            rd = 5'($urandom);
            instr = $urandom;
            ex_valid = 1'b1; ex_opcode = op; ex_alu_result = val; ex_rd = rd; ex_instruction = instr;
            step();
            n_checks++;
            if ({wb_valid, mem_stall, wb_exc, dmem_req_valid, wb_opcode, wb_rd} !== {4'b1000, op, rd}) begin
                n_fail++;
                $display("FAIL alu_flags[%0d]: got %b want %b", i,
                         {wb_valid, mem_stall, wb_exc, dmem_req_valid, wb_opcode, wb_rd}, {4'b1000, op, rd});
            end
            n_checks++;
            if ({wb_value, wb_instruction} !== {val, instr}) begin
                n_fail++;
                $display("FAIL alu_value[%0d]: got %h/%h want %h/%h", i, wb_value, wb_instruction, val, instr);
            end
        end
        ex_valid = 1'b1; ex_opcode = 7'h37;
        step();
        n_checks++;
        if ({wb_valid, mem_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL bubble_opcode: got %b want 00", {wb_valid, mem_stall});
        end
        ex_valid = 1'b0; ex_opcode = OP_R;
        step();
        n_checks++;
        if ({wb_valid, mem_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL bubble_invalid: got %b want 00", {wb_valid, mem_stall});
        end
    endtask

    task automatic test_store();
        do_mem_op("sh_example", 1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 2, 0, 32'h0);
        do_mem_op("sb_lane1", 1'b1, 3'd0, 32'h201, 32'h1234_56EF, 0, 0, 32'h0);
        do_mem_op("sw_word", 1'b1, 3'd2, 32'h300, 32'hDEAD_BEEF, 1, 0, 32'h0);
    endtask

    task automatic test_load();
        do_mem_op("lb_signed", 1'b0, 3'd0, 32'h103, 32'h0, 0, 4, 32'h80FF_FF00);
        do_mem_op("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 0, 4, 32'h80FF_FF00);
        do_mem_op("lh_upper", 1'b0, 3'd1, 32'h402, 32'h0, 1, 0, 32'h9234_5678);
        do_mem_op("lhu_upper", 1'b0, 3'd5, 32'h402, 32'h0, 0, 2, 32'h9234_5678);
        do_mem_op("ld_as_w", 1'b0, 3'd3, 32'h500, 32'h0, 0, 1, 32'hCAFE_F00D);
    endtask

    task automatic test_misaligned();
        do_mem_op("lw_misaligned", 1'b0, 3'd2, 32'h6, 32'h0, 0, 0, 32'h1122_3344);
        do_mem_op("sh_misaligned", 1'b1, 3'd1, 32'h13, 32'h0000_5A5A, 1, 0, 32'h0);
    endtask

    task automatic test_reset_mid_access();
        ex_valid = 1'b1; ex_opcode = OP_LD; ex_funct3 = 3'd2; ex_alu_result = 32'h40;
        step();
        ex_valid = 1'b0; ex_opcode = 7'h00;
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        n_checks++;
        if ({mem_stall, dmem_req_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_wait: got %b want 10", {mem_stall, dmem_req_valid});
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h7777_7777;
        n_checks++;
        if ({mem_stall, dmem_req_valid, wb_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_after: got %b want 000", {mem_stall, dmem_req_valid, wb_valid});
        end
        step();
        dmem_rsp_valid = 1'b0;
        n_checks++;
        if ({mem_stall, dmem_req_valid, wb_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_late_rsp: got %b want 000", {mem_stall, dmem_req_valid, wb_valid});
        end
    endtask

    task automatic test_back_to_back();
        int t0, hs0;
        int pulses[$];
        t0 = cyc; hs0 = n_hs;
        dmem_req_ready = 1'b1;
        ex_valid = 1'b1; ex_opcode = OP_ST; ex_funct3 = 3'd2; ex_alu_result = 32'h80; ex_store_data = 32'h1357_9BDF;
        for (int c = 1; c <= 6; c++) begin
            step();
            ex_valid = (c == 2); ex_opcode = (c == 2) ? OP_LD : 7'h00;
            if (c == 2) ex_alu_result = 32'h84;
            dmem_rsp_valid = (c == 4); dmem_rsp_data = 32'h2468_ACE0;
            if (wb_valid) pulses.push_back(cyc - t0);
        end
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; ex_valid = 1'b0;
        n_checks++;
        if (pulses.size() != 2 || pulses[0] != 2 || pulses[1] != 5) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %p want '{2, 5}", pulses);
        end
        n_checks++;
        if (n_hs - hs0 != 2) begin
            n_fail++;
            $display("FAIL b2b_handshakes: got %0d want 2", n_hs - hs0);
        end
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] val;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                do_mem_op($sformatf("rand%0d", i), kind < 3, 3'($urandom), $urandom & 32'hFFFF,
                          $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            end else begin
                val = $urandom;
                ex_valid = (kind != 9); ex_opcode = (kind == 8) ? 7'h6F : OP_I; ex_alu_result = val;
                step();
                ex_valid = 1'b0;
                n_checks++;
                if ({wb_valid, mem_stall} !== {kind < 8, 1'b0} || (kind < 8 && wb_value !== val)) begin
                    n_fail++;
                    $display("FAIL rand%0d_alu: got %b/%h want %b/%h", i, {wb_valid, mem_stall}, wb_value,
                             {kind < 8, 1'b0}, val);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_misaligned();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
